// File: rtl/lc_lab_pkg.sv
// Shared definitions for the logic-circuits lab blocks.
//   state_t       : sweep controller states
//   MODE_EQUIV    : channel check type, f_a must equal f_b
//   MODE_COMPL    : channel check type, f_a must equal ~f_b
//   is_mismatch() : per-channel mismatch rule for one sampled vector
package lc_lab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic MODE_EQUIV = 1'b0;
  localparam logic MODE_COMPL = 1'b1;

  // A complement pair is wrong when both outputs agree.
  // An equivalence pair is wrong when they differ.
  function automatic logic is_mismatch(input logic mode, input logic a, input logic b);
    return (mode == MODE_COMPL) ? (a == b) : (a != b);
  endfunction

endpackage

// File: rtl/tt_channel_check.sv
// One comparison channel of the truth-table sweeper. It accumulates results
// for one pair of external functions across a sweep.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : start of a new sweep; results return to their initial values
//   sample_en   : the current vector is settled and f_a/f_b are valid
//   mode_q      : captured check type (MODE_EQUIV / MODE_COMPL)
//   f_a, f_b    : the two implementation outputs
//   vec         : vector currently applied to the functions
//   mis         : combinational mismatch flag for the current vector
//   err_cnt     : number of mismatching vectors (WIDTH+1 bits, cannot overflow)
//   first_fail  : vector of the first mismatch
//   fail_valid  : first_fail holds a captured vector
//   pass        : no mismatch seen since clear
module tt_channel_check
  import lc_lab_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_en,
  input  logic             mode_q,
  input  logic             f_a,
  input  logic             f_b,
  input  logic [WIDTH-1:0] vec,
  output logic             mis,
  output logic [WIDTH:0]   err_cnt,
  output logic [WIDTH-1:0] first_fail,
  output logic             fail_valid,
  output logic             pass
);

  localparam int CNT_W = WIDTH + 1;

  assign mis = is_mismatch(mode_q, f_a, f_b);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt    <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
      pass       <= 1'b1;
    end else if (clear) begin
      err_cnt    <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
      pass       <= 1'b1;
    end else if (sample_en && mis) begin
      err_cnt <= err_cnt + CNT_W'(1);
      pass    <= 1'b0;
      if (!fail_valid) begin
        first_fail <= vec;
        fail_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Truth-table sweeper: walks vec through all 2^WIDTH values, holds each one
// for SETTLE idle cycles plus one sample cycle, and checks NCH external
// function pairs in parallel (equivalence or complement per channel).
//   clk, rst    : clock, asynchronous active-high reset
//   start       : sweep request, honoured only when idle
//   mode        : per-channel check type, captured at start
//   vec         : current input vector to all function pairs
//   f_a, f_b    : implementation outputs, one bit per channel
//   busy        : sweep in progress (settle and sample cycles)
//   done        : one-cycle pulse after the last sample
//   pass        : per channel, no mismatches in the last sweep
//   err_cnt     : packed per-channel mismatch counts, WIDTH+1 bits each
//   first_fail  : packed per-channel vector of the first mismatch
//   fail_valid  : per channel, first_fail is meaningful
//   aborted     : sweep ended early on a mismatch
// Build option TT_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first vector
// where any channel mismatches, holding vec at that value. Without it every
// sweep is complete and aborted is constant 0.
module tt_sweep_checker
  import lc_lab_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NCH    = 2,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NCH-1:0]           mode,
  output logic [WIDTH-1:0]         vec,
  input  logic [NCH-1:0]           f_a,
  input  logic [NCH-1:0]           f_b,
  output logic                     busy,
  output logic                     done,
  output logic [NCH-1:0]           pass,
  output logic [NCH*(WIDTH+1)-1:0] err_cnt,
  output logic [NCH*WIDTH-1:0]     first_fail,
  output logic [NCH-1:0]           fail_valid,
  output logic                     aborted
);

  localparam int               CW       = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]    SETTLE_C = CW'(SETTLE);
  localparam logic [WIDTH-1:0] VEC_LAST = '1;
  // With no settle time each new vector is sampled straight away.
  localparam state_t           ST_NEXT  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] vec_q;
  logic [NCH-1:0]   mode_q;
  logic [NCH-1:0]   mis;
  logic             accept, advance, sample_en, stop;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    advance   = 1'b0;
    sample_en = 1'b0;
    stop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CW'(1)) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        stop = |mis;
`endif
        // All-ones is terminal: vec never wraps back to zero.
        if (stop || vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          advance = 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        vec_q  <= '0;
        cnt_q  <= SETTLE_C;
        mode_q <= mode;
      end else if (advance) begin
        vec_q <= vec_q + WIDTH'(1);
        cnt_q <= SETTLE_C;
      end else if (state_q == ST_SETTLE) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
  logic aborted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         aborted_q <= 1'b0;
    else if (accept) aborted_q <= 1'b0;
    else if (stop)   aborted_q <= 1'b1;
  end

  assign aborted = aborted_q;
`else
  // Mismatch flags only steer the controller when stop-on-fail is built in.
  logic unused_mis;
  assign unused_mis = |mis;
  assign aborted    = 1'b0;
`endif

  assign vec  = vec_q;
  assign busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done = (state_q == ST_DONE);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    tt_channel_check #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .clear      (accept),
      .sample_en  (sample_en),
      .mode_q     (mode_q[gi]),
      .f_a        (f_a[gi]),
      .f_b        (f_b[gi]),
      .vec        (vec_q),
      .mis        (mis[gi]),
      .err_cnt    (err_cnt[gi*(WIDTH+1) +: WIDTH+1]),
      .first_fail (first_fail[gi*WIDTH +: WIDTH]),
      .fail_valid (fail_valid[gi]),
      .pass       (pass[gi])
    );
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench for tt_sweep_checker. Two instances run side by side
// with WIDTH=2, NCH=2: index 0 uses SETTLE=1, index 1 uses SETTLE=0. Both see
// the same start/mode/reset and the same set of lab functions, each evaluated
// on its own vec. A reference model predicts the whole sweep (length, final
// results) from the truth-table rules at the moment a start is accepted, and
// a compare process checks every output of both instances on every cycle.
module tb_tt_sweep_checker;

  localparam int W  = 2;
  localparam int N  = 2;
  localparam int NV = 1 << W;

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] mode  = '0;

  logic [W-1:0]       vec_d  [2];
  logic [N-1:0]       fa_d   [2];
  logic [N-1:0]       fb_d   [2];
  logic               busy_d [2];
  logic               done_d [2];
  logic [N-1:0]       pass_d [2];
  logic [N*(W+1)-1:0] err_d  [2];
  logic [N*W-1:0]     ff_d   [2];
  logic [N-1:0]       fv_d   [2];
  logic               ab_d   [2];

  // Function pair selection per channel, plus random truth tables for sel 4.
  int           fsel  [N];
  logic [NV-1:0] tab_a [N];
  logic [NV-1:0] tab_b [N];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  tt_sweep_checker #(.WIDTH(W), .NCH(N), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .vec(vec_d[0]),
    .f_a(fa_d[0]), .f_b(fb_d[0]), .busy(busy_d[0]), .done(done_d[0]),
    .pass(pass_d[0]), .err_cnt(err_d[0]), .first_fail(ff_d[0]),
    .fail_valid(fv_d[0]), .aborted(ab_d[0])
  );

  tt_sweep_checker #(.WIDTH(W), .NCH(N), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .vec(vec_d[1]),
    .f_a(fa_d[1]), .f_b(fb_d[1]), .busy(busy_d[1]), .done(done_d[1]),
    .pass(pass_d[1]), .err_cnt(err_d[1]), .first_fail(ff_d[1]),
    .fail_valid(fv_d[1]), .aborted(ab_d[1])
  );

  // The gate-level functions of the lab, returned as {f_a, f_b}.
  function automatic logic [1:0] lab_fn(input int sel, input logic [NV-1:0] ta,
                                        input logic [NV-1:0] tb, input logic [W-1:0] v);
    logic a, b;
    case (sel)
      0:       begin a = v[1] | (v[1] & v[0]); b = v[1];             end
      1:       begin a = v[0] ^ v[1];          b = v[0] ^ v[1];      end
      2:       begin a = v[1] & v[0];          b = ~v[1] | ~v[0];    end
      3:       begin a = v[1] & v[0];          b = v[1] | v[0];      end
      default: begin a = ta[v];                b = tb[v];            end
    endcase
    return {a, b};
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      fa_d[d] = '0;
      fb_d[d] = '0;
      for (int ch = 0; ch < N; ch++)
        {fa_d[d][ch], fb_d[d][ch]} = lab_fn(fsel[ch], tab_a[ch], tab_b[ch], vec_d[d]);
    end
  end

  // ---------------- reference model ----------------
  int           m_cyc  [2];     // -1 idle, else cycles since accepted start
  int           m_len  [2];     // busy cycles of the current/last sweep
  logic [W-1:0] m_vecf [2];     // vec value once the sweep is over
  int           m_err  [2][N];
  logic [W-1:0] m_ff   [2][N];
  bit           m_fv   [2][N];
  bit           m_pass [2][N];
  bit           m_ab   [2];

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic model_reset(input int d);
    m_cyc[d]  = -1;
    m_len[d]  = 1;
    m_vecf[d] = '0;
    m_ab[d]   = 1'b0;
    for (int ch = 0; ch < N; ch++) begin
      m_err[d][ch]  = 0;
      m_ff[d][ch]   = '0;
      m_fv[d][ch]   = 1'b0;
      m_pass[d][ch] = 1'b1;
    end
  endtask

  // Evaluate the whole truth table with the mode captured now.
  task automatic model_predict(input int d);
    int  nswept;
    bit  any;
    logic [1:0] ab;
    logic mis;
    model_reset(d);
    nswept = 0;
    for (int v = 0; v < NV; v++) begin
      nswept++;
      any = 1'b0;
      for (int ch = 0; ch < N; ch++) begin
        ab  = lab_fn(fsel[ch], tab_a[ch], tab_b[ch], W'(v));
        mis = mode[ch] ? (ab[1] == ab[0]) : (ab[1] != ab[0]);
        if (mis) begin
          any = 1'b1;
          m_err[d][ch]++;
          m_pass[d][ch] = 1'b0;
          if (!m_fv[d][ch]) begin
            m_ff[d][ch] = W'(v);
            m_fv[d][ch] = 1'b1;
          end
        end
      end
      m_vecf[d] = W'(v);
      if (STOP_ON_FAIL && any) begin
        m_ab[d] = 1'b1;
        break;
      end
    end
    m_len[d] = nswept * (settle_of(d) + 1);
    m_cyc[d] = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst)                   model_reset(d);
      else if (m_cyc[d] < 0)     begin if (start) model_predict(d); end
      else if (m_cyc[d] >= m_len[d]) m_cyc[d] = -1;
      else                       m_cyc[d]++;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        bit           e_busy, e_done;
        logic [W-1:0] e_vec;
        e_busy = (m_cyc[d] >= 0) && (m_cyc[d] < m_len[d]);
        e_done = (m_cyc[d] == m_len[d]);
        e_vec  = e_busy ? W'(m_cyc[d] / (settle_of(d) + 1)) : m_vecf[d];
        check($sformatf("busy[d%0d]", d), 32'(busy_d[d]), 32'(e_busy));
        check($sformatf("done[d%0d]", d), 32'(done_d[d]), 32'(e_done));
        check($sformatf("vec[d%0d]", d),  32'(vec_d[d]),  32'(e_vec));
        check($sformatf("aborted[d%0d]", d), 32'(ab_d[d]), 32'(e_busy ? 1'b0 : m_ab[d]));
        if (!e_busy) begin
          for (int ch = 0; ch < N; ch++) begin
            check($sformatf("err_cnt[d%0d ch%0d]", d, ch),
                  32'(err_d[d][ch*(W+1) +: W+1]), 32'(m_err[d][ch]));
            check($sformatf("first_fail[d%0d ch%0d]", d, ch),
                  32'(ff_d[d][ch*W +: W]), 32'(m_ff[d][ch]));
            check($sformatf("fail_valid[d%0d ch%0d]", d, ch),
                  32'(fv_d[d][ch]), 32'(m_fv[d][ch]));
            check($sformatf("pass[d%0d ch%0d]", d, ch),
                  32'(pass_d[d][ch]), 32'(m_pass[d][ch]));
          end
        end
      end
    end
  end

  // Busy-cycle and done-pulse counters used by the literal expectations.
  int blen [2];
  int dcnt [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (busy_d[d]) blen[d]++;
      if (done_d[d]) dcnt[d]++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_fn(input int s0, input int s1, input logic [N-1:0] m);
    fsel[0] = s0;
    fsel[1] = s1;
    mode    = m;
  endtask

  task automatic clr_counts();
    blen[0] = 0; blen[1] = 0;
    dcnt[0] = 0; dcnt[1] = 0;
  endtask

  task automatic do_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_d[0] && !busy_d[1] && !done_d[0] && !done_d[1]) begin
        seen = 1'b1;
        break;
      end
    end
    check("wait_idle", 32'(seen), 32'd1);
  endtask

  task automatic run_sweep();
    clr_counts();
    do_start();
    wait_idle(100);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    for (int ch = 0; ch < N; ch++) begin
      fsel[ch]  = 0;
      tab_a[ch] = '0;
      tab_b[ch] = '0;
    end
    clr_counts();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state, hand-computed.
    @(negedge clk);
    check("rst_busy", 32'(busy_d[0]), 32'd0);
    check("rst_pass", 32'(pass_d[0]), 32'b11);
    check("rst_err",  32'(err_d[0]),  32'd0);

    // Equivalence: a+(a*b) vs a, and xor vs xor.
    set_fn(0, 1, 2'b00);
    run_sweep();
    check("equiv_busy_s1", 32'(blen[0]), 32'd8);
    check("equiv_busy_s0", 32'(blen[1]), 32'd4);
    check("equiv_done",    32'(dcnt[0]), 32'd1);
    check("equiv_pass",    32'(pass_d[0]), 32'b11);
    check("equiv_err",     32'(err_d[0]),  32'd0);
    check("equiv_fv",      32'(fv_d[0]),   32'b00);

    // De Morgan complement check on channel 0.
    set_fn(2, 1, 2'b01);
    run_sweep();
    check("compl_pass0", 32'(pass_d[0][0]), 32'd1);
    check("compl_err0",  32'(err_d[0][2:0]), 32'd0);

    // Fault: and vs or under equivalence.
    set_fn(3, 1, 2'b00);
    run_sweep();
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    check("fault_abort",   32'(ab_d[0]),      32'd1);
    check("fault_vec",     32'(vec_d[0]),     32'd1);
    check("fault_err0",    32'(err_d[0][2:0]), 32'd1);
    check("fault_busy_s1", 32'(blen[0]),      32'd4);
    check("fault_busy_s0", 32'(blen[1]),      32'd2);
`else
    check("fault_err0",    32'(err_d[0][2:0]), 32'd2);
    check("fault_busy_s1", 32'(blen[0]),      32'd8);
    check("fault_busy_s0", 32'(blen[1]),      32'd4);
    check("fault_err0_s0", 32'(err_d[1][2:0]), 32'd2);
`endif
    check("fault_ff0",   32'(ff_d[0][1:0]), 32'b01);
    check("fault_fv",    32'(fv_d[0]),      32'b01);
    check("fault_pass",  32'(pass_d[0]),    32'b10);
    check("fault_err1",  32'(err_d[0][5:3]), 32'd0);
    check("fault_done",  32'(dcnt[0]),      32'd1);

    // start pulsed mid-sweep must not restart or extend the sweep.
    set_fn(0, 1, 2'b00);
    clr_counts();
    do_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_idle(100);
    check("restart_busy_s1", 32'(blen[0]), 32'd8);
    check("restart_busy_s0", 32'(blen[1]), 32'd4);
    check("restart_done",    32'(dcnt[0]), 32'd1);

    // Reset at vec=10 mid-sweep.
    set_fn(3, 1, 2'b00);
    clr_counts();
    do_start();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_d[0] && vec_d[0] == 2'b10) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_vec10", 32'(seen), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy_d[0]), 32'd0);
    check("mid_rst_done", 32'(done_d[0]), 32'd0);
    check("mid_rst_vec",  32'(vec_d[0]),  32'd0);
    check("mid_rst_pass", 32'(pass_d[0]), 32'b11);
    check("mid_rst_err",  32'(err_d[0]),  32'd0);
    check("mid_rst_ff",   32'(ff_d[0]),   32'd0);
    check("mid_rst_fv",   32'(fv_d[0]),   32'd0);
    check("mid_rst_ab",   32'(ab_d[0]),   32'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    check("mid_rst_nodone", 32'(dcnt[0]), 32'd0);
    set_fn(0, 1, 2'b00);
    run_sweep();
    check("post_rst_busy", 32'(blen[0]), 32'd8);
    check("post_rst_pass", 32'(pass_d[0]), 32'b11);

    // Randomized sweeps: random functions, modes, mid-sweep mode changes and
    // stray start pulses.
    for (int it = 0; it < 40; it++) begin
      for (int ch = 0; ch < N; ch++) begin
        fsel[ch]  = int'($urandom_range(0, 4));
        tab_a[ch] = NV'($urandom);
        tab_b[ch] = NV'($urandom);
      end
      mode = N'($urandom);
      do_start();
      for (int c = 0; c < int'($urandom_range(0, 10)); c++) begin
        @(posedge clk);
        #2;
        mode  = N'($urandom);
        start = ($urandom_range(0, 3) == 0);
      end
      #0 start = 1'b0;
      wait_idle(100);
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1);
  end

endmodule
